// File: rtl/load_unit_pkg.sv
// Shared types and constants for the load unit: FSM states, RV32I load
// func3 encodings, default bus timeout and the misalignment predicate.
package load_unit_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;

  localparam int unsigned DefaultTimeoutCycles = 16;

  // Halfwords need addr[0]=0; words (and the encodings decoded as LW) need addr[1:0]=0.
  function automatic logic load_misaligned(input logic [2:0] func3, input logic [1:0] offset);
    logic mis;
    case (func3)
      F3Lb, F3Lbu: mis = 1'b0;
      F3Lh, F3Lhu: mis = offset[0];
      default:     mis = (offset != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_unit_if.sv
// Execute/memory/writeback signal bundle of the load unit.
// slave: the load unit itself; master: the surrounding pipeline and memory.
interface load_unit_if;
  logic        load_req_in;
  logic [2:0]  func3_in;
  logic [31:0] iadder_in;
  logic [31:0] dmaddr_out;
  logic        dmrd_req_out;
  logic        dmrd_ack_in;
  logic [31:0] dmdata_in;
  logic [31:0] lu_data_out;
  logic        lu_valid_out;
  logic        lu_err_out;
  logic        lu_busy_out;

  modport slave (
    input  load_req_in, func3_in, iadder_in, dmrd_ack_in, dmdata_in,
    output dmaddr_out, dmrd_req_out, lu_data_out, lu_valid_out, lu_err_out, lu_busy_out
  );

  modport master (
    output load_req_in, func3_in, iadder_in, dmrd_ack_in, dmdata_in,
    input  dmaddr_out, dmrd_req_out, lu_data_out, lu_valid_out, lu_err_out, lu_busy_out
  );
endinterface

// File: rtl/load_unit_extract.sv
// load_extract: combinational byte/halfword/word select and sign/zero
// extension of a memory read word, using the latched address offset.
module load_extract
  import load_unit_pkg::*;
(
  input  logic [2:0]  func3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] word_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select, then extend according to the load type.
  always_comb begin
    byte_sel = word_i[7:0];
    case (offset_i)
      2'd0: byte_sel = word_i[7:0];
      2'd1: byte_sel = word_i[15:8];
      2'd2: byte_sel = word_i[23:16];
      2'd3: byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
    half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];

    case (func3_i)
      F3Lb:    result_o = {{24{byte_sel[7]}}, byte_sel};
      F3Lbu:   result_o = {24'h0, byte_sel};
      F3Lh:    result_o = {{16{half_sel[15]}}, half_sel};
      F3Lhu:   result_o = {16'h0, half_sel};
      default: result_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// load_unit: data-memory read path. Issues a word-aligned read, waits for
// the acknowledge (with optional timeout), extracts/extends the result and
// pulses valid or error to writeback. Stalls the pipeline while waiting.
// Optional: LOAD_MISALIGN_TRAP_EN traps misaligned LH/LHU/LW without a bus access.
module load_unit
  import load_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
  input  logic     clk_in,
  input  logic     rst_in,
  load_unit_if.slave bus
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_e          state_q, state_d;
  logic [2:0]      func3_q, func3_d;
  logic [1:0]      off_q, off_d;
  logic [31:0]     addr_q, addr_d;
  logic            req_q, req_d;
  logic [31:0]     data_q, data_d;
  logic            err_q, err_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     cnt_inc;
  logic [31:0]     ext_result;

  load_extract u_extract (
    .func3_i  (func3_q),
    .offset_i (off_q),
    .word_i   (bus.dmdata_in),
    .result_o (ext_result)
  );

  // State and datapath registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= StIdle;
      func3_q <= 3'b000;
      off_q   <= 2'b00;
      addr_q  <= 32'h0;
      req_q   <= 1'b0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      func3_q <= func3_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: accept in IDLE/RESP, wait for ack or timeout, respond.
  always_comb begin
    state_d = state_q;
    func3_d = func3_q;
    off_d   = off_q;
    addr_d  = addr_q;
    req_d   = req_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    cnt_inc = 32'(cnt_q) + 32'd1;

    case (state_q)
      StIdle, StResp: begin
        if (bus.load_req_in) begin
          func3_d = bus.func3_in;
          off_d   = bus.iadder_in[1:0];
          cnt_d   = '0;
          addr_d  = {bus.iadder_in[31:2], 2'b00};
          req_d   = 1'b1;
          err_d   = 1'b0;
          state_d = StWait;
`ifdef LOAD_MISALIGN_TRAP_EN
          if (load_misaligned(bus.func3_in, bus.iadder_in[1:0])) begin
            addr_d  = addr_q;
            req_d   = 1'b0;
            err_d   = 1'b1;
            data_d  = 32'h0;
            state_d = StResp;
          end
`endif
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (bus.dmrd_ack_in) begin
          // Ack wins over a coincident timeout.
          data_d  = ext_result;
          req_d   = 1'b0;
          err_d   = 1'b0;
          state_d = StResp;
        end else begin
          cnt_d = cnt_inc[CntW-1:0];
          if ((TIMEOUT_CYCLES != 0) && (cnt_inc == TIMEOUT_CYCLES)) begin
            req_d   = 1'b0;
            err_d   = 1'b1;
            data_d  = 32'h0;
            state_d = StResp;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.dmaddr_out   = addr_q;
  assign bus.dmrd_req_out = req_q;
  assign bus.lu_data_out  = data_q;
  assign bus.lu_valid_out = (state_q == StResp) && !err_q;
  assign bus.lu_err_out   = (state_q == StResp) && err_q;
  assign bus.lu_busy_out  = (state_q == StWait);

endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit: table of load vectors, scoreboard of
// expected writeback results, plus hand sequences for back-to-back, reset,
// timeout (separate instance with TIMEOUT_CYCLES=4) and misaligned loads.
module tb_load_unit;
  import load_unit_pkg::*;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] word;
    int          delay;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } sb_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  sb_t  sb_q[$];
  sb_t  mon_ent;
  vec_t vecs[10];

  load_unit_if bus ();
  load_unit_if bus_to ();

  load_unit dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  load_unit #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every valid/err pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && (bus.lu_valid_out || bus.lu_err_out)) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: valid=%b err=%b data=%h with none expected",
                 bus.lu_valid_out, bus.lu_err_out, bus.lu_data_out);
      end else begin
        mon_ent = sb_q.pop_front();
        check1("sb_err", bus.lu_err_out, mon_ent.err);
        check1("sb_valid", bus.lu_valid_out, !mon_ent.err);
        check("sb_data", bus.lu_data_out, mon_ent.data);
      end
    end
  end

  // Called just after a negedge with the unit in IDLE or RESP; returns in the RESP cycle.
  task automatic run_load(input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] word, input int delay, input logic [31:0] exp);
    sb_t ent;
    logic [31:0] waddr;
    waddr = {addr[31:2], 2'b00};
    bus.load_req_in = 1'b1;
    bus.func3_in    = f3;
    bus.iadder_in   = addr;
    ent.data = exp;
    ent.err  = 1'b0;
    sb_q.push_back(ent);
    @(negedge clk);
    bus.load_req_in = 1'b0;
    bus.iadder_in   = 32'hFFFF_FFFF;
    check1("req_issued", bus.dmrd_req_out, 1'b1);
    check("dmaddr", bus.dmaddr_out, waddr);
    check1("busy_wait", bus.lu_busy_out, 1'b1);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check1("req_held", bus.dmrd_req_out, 1'b1);
      check("dmaddr_held", bus.dmaddr_out, waddr);
      check1("busy_held", bus.lu_busy_out, 1'b1);
    end
    bus.dmrd_ack_in = 1'b1;
    bus.dmdata_in   = word;
    @(negedge clk);
    bus.dmrd_ack_in = 1'b0;
    bus.dmdata_in   = 32'h0;
    check1("valid_resp", bus.lu_valid_out, 1'b1);
    check1("req_dropped", bus.dmrd_req_out, 1'b0);
    check1("busy_resp", bus.lu_busy_out, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{F3Lb,   32'h0000_1003, 32'h80FF_1234, 0, 32'hFFFF_FF80};
    vecs[1] = '{F3Lhu,  32'h0000_2002, 32'hBEEF_CAFE, 0, 32'h0000_BEEF};
    vecs[2] = '{F3Lh,   32'h0000_2002, 32'hBEEF_CAFE, 0, 32'hFFFF_BEEF};
    vecs[3] = '{F3Lbu,  32'h0000_1003, 32'h80FF_1234, 1, 32'h0000_0080};
    vecs[4] = '{F3Lb,   32'h0000_1001, 32'h80FF_1234, 0, 32'h0000_0012};
    vecs[5] = '{F3Lh,   32'h0000_2000, 32'hBEEF_CAFE, 2, 32'hFFFF_CAFE};
    vecs[6] = '{F3Lw,   32'h0000_3000, 32'h1234_5678, 5, 32'h1234_5678};
    vecs[7] = '{F3Lbu,  32'h0000_4002, 32'h00A5_0000, 2, 32'h0000_00A5};
    vecs[8] = '{3'b011, 32'h0000_5004, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF};
    vecs[9] = '{3'b110, 32'h0000_5008, 32'h0BAD_F00D, 1, 32'h0BAD_F00D};

    rst = 1'b1;
    bus.load_req_in = 1'b0;    bus.func3_in = 3'b000;     bus.iadder_in = 32'h0;
    bus.dmrd_ack_in = 1'b0;    bus.dmdata_in = 32'h0;
    bus_to.load_req_in = 1'b0; bus_to.func3_in = 3'b000;  bus_to.iadder_in = 32'h0;
    bus_to.dmrd_ack_in = 1'b0; bus_to.dmdata_in = 32'h0;
    repeat (2) @(negedge clk);
    check1("rst_req", bus.dmrd_req_out, 1'b0);
    check("rst_addr", bus.dmaddr_out, 32'h0);
    check("rst_data", bus.lu_data_out, 32'h0);
    check1("rst_valid", bus.lu_valid_out, 1'b0);
    check1("rst_err", bus.lu_err_out, 1'b0);
    check1("rst_busy", bus.lu_busy_out, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Table vectors, one idle cycle between loads.
    for (int i = 0; i < 10; i++) begin
      run_load(vecs[i].f3, vecs[i].addr, vecs[i].word, vecs[i].delay, vecs[i].exp);
      @(negedge clk);
      check1("idle_after", bus.lu_busy_out, 1'b0);
    end

    // Back-to-back: second load accepted in the RESP cycle of the first.
    run_load(F3Lw, 32'h0000_7000, 32'hCAFE_0001, 1, 32'hCAFE_0001);
    run_load(F3Lw, 32'h0000_7004, 32'hCAFE_0002, 0, 32'hCAFE_0002);
    run_load(F3Lhu, 32'h0000_7006, 32'h5A5A_1111, 0, 32'h0000_5A5A);
    @(negedge clk);

    // Reset while waiting: request drops asynchronously, no result.
    bus.load_req_in = 1'b1;
    bus.func3_in    = F3Lw;
    bus.iadder_in   = 32'h0000_8000;
    @(negedge clk);
    bus.load_req_in = 1'b0;
    check1("pre_rst_req", bus.dmrd_req_out, 1'b1);
    #2 rst = 1'b1;
    #1;
    check1("async_rst_req", bus.dmrd_req_out, 1'b0);
    check1("async_rst_busy", bus.lu_busy_out, 1'b0);
    check1("async_rst_valid", bus.lu_valid_out, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check1("post_rst_idle", bus.lu_busy_out, 1'b0);
    run_load(F3Lb, 32'h0000_8002, 32'h0011_2233, 0, 32'h0000_0011);
    @(negedge clk);

    // Timeout instance: four WAIT cycles without ack raise an error.
    bus_to.load_req_in = 1'b1;
    bus_to.func3_in    = F3Lw;
    bus_to.iadder_in   = 32'h0000_6000;
    @(negedge clk);
    bus_to.load_req_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check1("to_req_held", bus_to.dmrd_req_out, 1'b1);
      check1("to_busy", bus_to.lu_busy_out, 1'b1);
      check1("to_no_err_early", bus_to.lu_err_out, 1'b0);
      @(negedge clk);
    end
    check1("to_err", bus_to.lu_err_out, 1'b1);
    check1("to_not_valid", bus_to.lu_valid_out, 1'b0);
    check("to_data_zero", bus_to.lu_data_out, 32'h0);
    check1("to_req_dropped", bus_to.dmrd_req_out, 1'b0);
    @(negedge clk);
    check1("to_err_pulse", bus_to.lu_err_out, 1'b0);

    // Ack on the fourth WAIT cycle wins over the timeout.
    bus_to.load_req_in = 1'b1;
    bus_to.iadder_in   = 32'h0000_6004;
    @(negedge clk);
    bus_to.load_req_in = 1'b0;
    repeat (3) @(negedge clk);
    bus_to.dmrd_ack_in = 1'b1;
    bus_to.dmdata_in   = 32'h7777_AAAA;
    @(negedge clk);
    bus_to.dmrd_ack_in = 1'b0;
    check1("ack_wins_valid", bus_to.lu_valid_out, 1'b1);
    check1("ack_wins_err", bus_to.lu_err_out, 1'b0);
    check("ack_wins_data", bus_to.lu_data_out, 32'h7777_AAAA);
    @(negedge clk);

    // Misaligned word/halfword loads.
`ifdef LOAD_MISALIGN_TRAP_EN
    begin
      sb_t ent;
      ent.data = 32'h0;
      ent.err  = 1'b1;
      bus.load_req_in = 1'b1;
      bus.func3_in    = F3Lw;
      bus.iadder_in   = 32'h0000_1001;
      sb_q.push_back(ent);
      @(negedge clk);
      bus.load_req_in = 1'b0;
      check1("trap_no_req", bus.dmrd_req_out, 1'b0);
      check1("trap_err", bus.lu_err_out, 1'b1);
      check1("trap_not_busy", bus.lu_busy_out, 1'b0);
      @(negedge clk);
      bus.load_req_in = 1'b1;
      bus.func3_in    = F3Lhu;
      bus.iadder_in   = 32'h0000_2003;
      sb_q.push_back(ent);
      @(negedge clk);
      bus.load_req_in = 1'b0;
      check1("trap_h_no_req", bus.dmrd_req_out, 1'b0);
      check1("trap_h_err", bus.lu_err_out, 1'b1);
      @(negedge clk);
    end
`else
    run_load(F3Lw, 32'h0000_1001, 32'h1122_3344, 0, 32'h1122_3344);
    @(negedge clk);
    run_load(F3Lhu, 32'h0000_2003, 32'hBEEF_CAFE, 0, 32'h0000_BEEF);
    @(negedge clk);
`endif

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
